// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Sequences the multi-cycle multiplier and divider cores that sit behind the
// EX-stage ALU and owns the architected HI/LO registers.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid, flush          EX holds a real instruction / kill EX this cycle
//   req_func, req_sign       FUNC_MUL / FUNC_DIV / 0, signedness
//   source_a, source_b       operands (rs / rt)
//   hi_write, lo_write       MTHI / MTLO strobes, with *_write_data
//   hi, lo                   architected HI/LO
//   stall                    hold IF/ID/EX
//   mul_start, div_start     single-cycle start pulses
//   mul_abort, div_abort     single-cycle abort pulses
//   op_sign, op_a, op_b      latched operation to both cores
//   mul_done, mul_result     multiplier handshake, {hi, lo} product
//   div_done, div_quot, div_rem  divider handshake
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO applied here
// MUL   | multiplier running, pipeline held
// DIV   | divider running, pipeline held
// DONE  | instruction leaves EX; pending result committed to HI/LO

`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_FUNC
`define W_FUNC 5
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 5'd1
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'd2
`endif

module muldiv_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 flush,
  input  logic [`W_FUNC-1:0]   req_func,
  input  logic                 req_sign,
  input  logic [`W_DATA-1:0]   source_a,
  input  logic [`W_DATA-1:0]   source_b,
  input  logic                 hi_write,
  input  logic                 lo_write,
  input  logic [`W_DATA-1:0]   hi_write_data,
  input  logic [`W_DATA-1:0]   lo_write_data,
  output logic [`W_DATA-1:0]   hi,
  output logic [`W_DATA-1:0]   lo,
  output logic                 stall,
  output logic                 mul_start,
  output logic                 div_start,
  output logic                 mul_abort,
  output logic                 div_abort,
  output logic                 op_sign,
  output logic [`W_DATA-1:0]   op_a,
  output logic [`W_DATA-1:0]   op_b,
  input  logic                 mul_done,
  input  logic [2*`W_DATA-1:0] mul_result,
  input  logic                 div_done,
  input  logic [`W_DATA-1:0]   div_quot,
  input  logic [`W_DATA-1:0]   div_rem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [`W_DATA-1:0] pend_hi, pend_lo;
  logic               commit;

  logic live, is_mul, is_div, div_zero;

  assign live     = ex_valid & ~flush;
  assign is_mul   = (req_func == `FUNC_MUL);
  assign is_div   = (req_func == `FUNC_DIV);
  assign div_zero = (source_b == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; flush always wins over a coincident done
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (live && is_mul)                  state_next = S_MUL;
        else if (live && is_div && !div_zero) state_next = S_DIV;
        else if (live && is_div && div_zero)  state_next = S_DONE;
      end
      S_MUL: begin
        if (flush)         state_next = S_IDLE;
        else if (mul_done) state_next = S_DONE;
      end
      S_DIV: begin
        if (flush)         state_next = S_IDLE;
        else if (div_done) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs; everything is forced quiet while rst is held since the state
  // register may still hold a stale value during the first reset cycle.
  always_comb begin
    stall     = 1'b0;
    mul_start = 1'b0;
    div_start = 1'b0;
    mul_abort = 1'b0;
    div_abort = 1'b0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          stall     = live & (is_mul | is_div);
          mul_start = live & is_mul;
          div_start = live & is_div & ~div_zero;
        end
        S_MUL: begin
          stall     = ~flush;
          mul_abort = flush;
        end
        S_DIV: begin
          stall     = ~flush;
          div_abort = flush;
        end
        default: ;
      endcase
    end
  end

  // Datapath: operand latch, pending result, HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      commit  <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_sign <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (live && (is_mul || (is_div && !div_zero))) begin
            op_a    <= source_a;
            op_b    <= source_b;
            op_sign <= req_sign;
          end else if (live && is_div) begin
            // divide by zero: leave HI/LO untouched
            commit <= 1'b0;
          end else if (live) begin
            if (hi_write) hi <= hi_write_data;
            if (lo_write) lo <= lo_write_data;
          end
        end
        S_MUL: begin
          if (mul_done && !flush) begin
            pend_hi <= mul_result[2*`W_DATA-1:`W_DATA];
            pend_lo <= mul_result[`W_DATA-1:0];
            commit  <= 1'b1;
          end
        end
        S_DIV: begin
          if (div_done && !flush) begin
            pend_hi <= div_rem;
            pend_lo <= div_quot;
            commit  <= 1'b1;
          end
        end
        S_DONE: begin
          if (commit && !flush) begin
            hi <= pend_hi;
            lo <= pend_lo;
          end
          commit <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef W_FUNC
`define W_FUNC 5
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 5'd1
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'd2
`endif

module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst, ex_valid, flush, req_sign;
  logic [4:0]  req_func;
  logic [31:0] source_a, source_b;
  logic        hi_write, lo_write;
  logic [31:0] hi_write_data, lo_write_data;
  logic [31:0] hi, lo, op_a, op_b;
  logic        stall, mul_start, div_start, mul_abort, div_abort, op_sign;
  logic        mul_done, div_done;
  logic [63:0] mul_result;
  logic [31:0] div_quot, div_rem;

  int errors = 0;
  int checks = 0;
  int cnt;
  logic start_seen;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush(flush),
    .req_func(req_func), .req_sign(req_sign),
    .source_a(source_a), .source_b(source_b),
    .hi_write(hi_write), .lo_write(lo_write),
    .hi_write_data(hi_write_data), .lo_write_data(lo_write_data),
    .hi(hi), .lo(lo), .stall(stall),
    .mul_start(mul_start), .div_start(div_start),
    .mul_abort(mul_abort), .div_abort(div_abort),
    .op_sign(op_sign), .op_a(op_a), .op_b(op_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after driving inputs
  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; flush = 0; req_func = 0; req_sign = 0;
    hi_write = 0; lo_write = 0;
    mul_done = 0; div_done = 0;
  endtask

  task automatic request(input logic [4:0] f, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1; req_func = f; req_sign = s; source_a = a; source_b = b;
  endtask

  initial begin
    idle_inputs();
    rst = 1; source_a = 0; source_b = 0;
    hi_write_data = 0; lo_write_data = 0;
    mul_result = 0; div_quot = 0; div_rem = 0;

    // ---- reset ----
    step(); step();
    request(`FUNC_MUL, 1, 32'd7, 32'd9);
    settle();
    chk("rst_stall", stall, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_sign", op_sign, 0);
    idle_inputs();
    rst = 0;
    step();

    // ---- signed MUL -3 x 5, k = 3 ----
    request(`FUNC_MUL, 1, 32'hFFFFFFFD, 32'd5);
    settle();
    chk("mul_c0_start", mul_start, 1);
    chk("mul_c0_stall", stall, 1);
    step();
    settle();
    chk("mul_c1_start", mul_start, 0);
    chk("mul_c1_stall", stall, 1);
    chk("mul_op_a", op_a, 32'hFFFFFFFD);
    chk("mul_op_b", op_b, 32'd5);
    chk("mul_op_sign", op_sign, 1);
    step();
    settle();
    chk("mul_c2_stall", stall, 1);
    step();
    mul_done = 1; mul_result = 64'hFFFFFFFF_FFFFFFF1;
    settle();
    chk("mul_c3_stall", stall, 1);
    step();
    mul_done = 0;
    settle();
    chk("mul_done_stall", stall, 0);
    chk("mul_done_nostart", mul_start, 0);
    step();
    idle_inputs();
    settle();
    chk("mul_hi", hi, 32'hFFFFFFFF);
    chk("mul_lo", lo, 32'hFFFFFFF1);

    // ---- unsigned DIV 100 / 7, k = 32 ----
    request(`FUNC_DIV, 0, 32'd100, 32'd7);
    settle();
    chk("div_c0_start", div_start, 1);
    cnt = 0; start_seen = 0;
    for (int i = 0; i < 34; i++) begin
      if (i == 32) begin div_done = 1; div_quot = 32'd14; div_rem = 32'd2; end
      else div_done = 0;
      settle();
      if (stall) cnt++;
      if (i > 0 && div_start) start_seen = 1;
      step();
    end
    idle_inputs();
    chk("div_stall_cycles", cnt, 33);
    chk("div_no_reissue", start_seen, 0);
    settle();
    chk("div_lo", lo, 32'd14);
    chk("div_hi", hi, 32'd2);

    // ---- MTHI/MTLO then divide by zero ----
    ex_valid = 1; hi_write = 1; lo_write = 1;
    hi_write_data = 32'h11; lo_write_data = 32'h22;
    settle();
    chk("mt_stall", stall, 0);
    step();
    idle_inputs();
    settle();
    chk("mt_hi", hi, 32'h11);
    chk("mt_lo", lo, 32'h22);
    request(`FUNC_DIV, 1, 32'd55, 32'd0);
    settle();
    chk("dz_no_start", div_start, 0);
    chk("dz_stall", stall, 1);
    step();
    settle();
    chk("dz_done_stall", stall, 0);
    step();
    idle_inputs();
    settle();
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    // ---- flush 5 cycles into DIV, late done ignored ----
    request(`FUNC_DIV, 0, 32'd50, 32'd3);
    settle();
    chk("fl_div_start", div_start, 1);
    for (int i = 0; i < 5; i++) step();
    flush = 1;
    settle();
    chk("fl_div_abort", div_abort, 1);
    chk("fl_div_stall", stall, 0);
    step();
    idle_inputs();
    div_done = 1; div_quot = 32'hAAAA; div_rem = 32'hBBBB;
    settle();
    chk("fl_abort_single", div_abort, 0);
    chk("fl_late_stall", stall, 0);
    step();
    div_done = 0;
    step();
    settle();
    chk("fl_div_hi", hi, 32'h11);
    chk("fl_div_lo", lo, 32'h22);

    // ---- flush coincident with mul_done ----
    request(`FUNC_MUL, 0, 32'd3, 32'd4);
    step();
    mul_done = 1; mul_result = 64'h12345678_9ABCDEF0; flush = 1;
    settle();
    chk("fmd_abort", mul_abort, 1);
    chk("fmd_stall", stall, 0);
    step();
    idle_inputs();
    step(); step();
    settle();
    chk("fmd_hi", hi, 32'h11);
    chk("fmd_lo", lo, 32'h22);

    // ---- flush in DONE ----
    request(`FUNC_MUL, 0, 32'd3, 32'd4);
    step();
    mul_done = 1; mul_result = 64'h0_0000000C;
    step();
    mul_done = 0; flush = 1;
    settle();
    chk("fdone_abort", mul_abort, 0);
    step();
    idle_inputs();
    step();
    settle();
    chk("fdone_hi", hi, 32'h11);
    chk("fdone_lo", lo, 32'h22);

    // ---- MTHI then back-to-back MULTU ----
    ex_valid = 1; hi_write = 1; hi_write_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    request(`FUNC_MUL, 0, 32'hFFFFFFFF, 32'd2);
    settle();
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_lo_kept", lo, 32'h22);
    chk("multu_start", mul_start, 1);
    step();
    mul_done = 1; mul_result = 64'h00000001_FFFFFFFE;
    step();
    mul_done = 0;
    step();
    idle_inputs();
    settle();
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // ---- reset mid-MUL ----
    request(`FUNC_MUL, 1, 32'd9, 32'd9);
    step(); step();
    rst = 1;
    settle();
    chk("rstm_stall", stall, 0);
    chk("rstm_abort", mul_abort, 0);
    step();
    rst = 0;
    idle_inputs();
    settle();
    chk("rstm_stall_after", stall, 0);
    chk("rstm_hi", hi, 0);
    chk("rstm_lo", lo, 0);
    request(`FUNC_MUL, 0, 32'd1, 32'd1);
    settle();
    chk("rstm_idle_start", mul_start, 1);
    step();
    idle_inputs();
    flush = 1;
    settle();
    chk("rstm_flush_abort", mul_abort, 1);
    step();
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
